// File: rtl/ex_mem_reg.sv
// ex_mem_reg: EX/MEM pipeline register for the five-stage OpenMIPS core.
// Latches the EX result bundle once per cycle and presents it to MEM.
// Inserts a NOP bubble when EX stalls while MEM proceeds, and holds the
// partial madd/msub accumulator (hilo) and step count (cnt) for EX across
// that bubble.
// Optional feature: define EXMEM_PERF_CNT_EN to add the 32-bit bubble_cnt
// performance counter and its output port.

module ex_mem_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [4:0]  ex_wd,
  input  logic        ex_wreg,
  input  logic [31:0] ex_wdata,
  input  logic [31:0] ex_hi,
  input  logic [31:0] ex_lo,
  input  logic        ex_whilo,
  input  logic [63:0] hilo_i,
  input  logic [1:0]  cnt_i,
  output logic [4:0]  mem_wd,
  output logic        mem_wreg,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_hi,
  output logic [31:0] mem_lo,
  output logic        mem_whilo,
  output logic [63:0] hilo_o,
`ifdef EXMEM_PERF_CNT_EN
  output logic [31:0] bubble_cnt,
`endif
  output logic [1:0]  cnt_o
);

  // Only the EX (bit 3) and MEM (bit 4) stall bits matter here.
  logic w_unused_stall;
  assign w_unused_stall = ^{stall[5], stall[2:0]};

  // Bubble: EX is stalled but MEM keeps going, so MEM must see a NOP.
  // Advance: both stages move. Any other stall combination is a hold
  // (stall[3]=0 with stall[4]=1 is illegal and treated as a hold too).
  logic w_bubble;
  logic w_advance;
  assign w_bubble  = stall[3] & ~stall[4];
  assign w_advance = ~stall[3] & ~stall[4];

  logic [4:0]  r_wd;
  logic        r_wreg;
  logic [31:0] r_wdata;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_whilo;
  logic [63:0] r_hilo;
  logic [1:0]  r_cnt;

  // Pipeline register update: reset, then flush, bubble, advance, hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wd    <= 5'd0;
      r_wreg  <= 1'b0;
      r_wdata <= 32'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_whilo <= 1'b0;
      r_hilo  <= 64'd0;
      r_cnt   <= 2'd0;
    end else if (flush) begin
      r_wd    <= 5'd0;
      r_wreg  <= 1'b0;
      r_wdata <= 32'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_whilo <= 1'b0;
      r_hilo  <= 64'd0;
      r_cnt   <= 2'd0;
    end else if (w_bubble) begin
      // MEM gets a NOP; the madd/msub intermediate is carried for EX.
      r_wd    <= 5'd0;
      r_wreg  <= 1'b0;
      r_wdata <= 32'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_whilo <= 1'b0;
      r_hilo  <= hilo_i;
      r_cnt   <= cnt_i;
    end else if (w_advance) begin
      r_wd    <= ex_wd;
      r_wreg  <= ex_wreg;
      r_wdata <= ex_wdata;
      r_hi    <= ex_hi;
      r_lo    <= ex_lo;
      r_whilo <= ex_whilo;
      r_hilo  <= 64'd0;
      r_cnt   <= 2'd0;
    end else begin
      r_wd    <= r_wd;
      r_wreg  <= r_wreg;
      r_wdata <= r_wdata;
      r_hi    <= r_hi;
      r_lo    <= r_lo;
      r_whilo <= r_whilo;
      r_hilo  <= r_hilo;
      r_cnt   <= r_cnt;
    end
  end

  assign mem_wd    = r_wd;
  assign mem_wreg  = r_wreg;
  assign mem_wdata = r_wdata;
  assign mem_hi    = r_hi;
  assign mem_lo    = r_lo;
  assign mem_whilo = r_whilo;
  assign hilo_o    = r_hilo;
  assign cnt_o     = r_cnt;

`ifdef EXMEM_PERF_CNT_EN
  logic [31:0] r_bubble_cnt;

  // Count bubble cycles; flush suppresses the count, only rst clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bubble_cnt <= 32'd0;
    end else if (!flush && w_bubble) begin
      r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end else begin
      r_bubble_cnt <= r_bubble_cnt;
    end
  end

  assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// Testbench for ex_mem_reg: table-driven vectors checked through a
// scoreboard queue, plus hand-written reset and counter corner cases.
// Define EXMEM_PERF_CNT_EN to also check the bubble counter.

module tb_ex_mem_reg;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic [31:0] ex_hi;
  logic [31:0] ex_lo;
  logic        ex_whilo;
  logic [63:0] hilo_i;
  logic [1:0]  cnt_i;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic        mem_whilo;
  logic [63:0] hilo_o;
  logic [1:0]  cnt_o;
`ifdef EXMEM_PERF_CNT_EN
  logic [31:0] bubble_cnt;
`endif

  ex_mem_reg dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .flush     (flush),
    .ex_wd     (ex_wd),
    .ex_wreg   (ex_wreg),
    .ex_wdata  (ex_wdata),
    .ex_hi     (ex_hi),
    .ex_lo     (ex_lo),
    .ex_whilo  (ex_whilo),
    .hilo_i    (hilo_i),
    .cnt_i     (cnt_i),
    .mem_wd    (mem_wd),
    .mem_wreg  (mem_wreg),
    .mem_wdata (mem_wdata),
    .mem_hi    (mem_hi),
    .mem_lo    (mem_lo),
    .mem_whilo (mem_whilo),
    .hilo_o    (hilo_o),
`ifdef EXMEM_PERF_CNT_EN
    .bubble_cnt(bubble_cnt),
`endif
    .cnt_o     (cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  stall;
    logic        flush;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        whilo;
    logic [63:0] hilo;
    logic [1:0]  cnt;
    logic [4:0]  e_wd;
    logic        e_wreg;
    logic [31:0] e_wdata;
    logic [31:0] e_hi;
    logic [31:0] e_lo;
    logic        e_whilo;
    logic [63:0] e_hilo;
    logic [1:0]  e_cnt;
    logic [31:0] e_bub;
  } vec_t;

  typedef struct {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        whilo;
    logic [63:0] hilo;
    logic [1:0]  cnt;
    logic [31:0] bub;
  } exp_t;

  localparam int NV = 15;
  vec_t vecs [NV];
  exp_t sb_q [$];
  int checks;
  int failures;

  function automatic vec_t mkv(
    input logic [5:0] st, input logic fl,
    input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
    input logic [31:0] hi, input logic [31:0] lo, input logic whilo,
    input logic [63:0] hilo, input logic [1:0] cnt,
    input logic [4:0] e_wd, input logic e_wreg, input logic [31:0] e_wdata,
    input logic [31:0] e_hi, input logic [31:0] e_lo, input logic e_whilo,
    input logic [63:0] e_hilo, input logic [1:0] e_cnt, input logic [31:0] e_bub);
    vec_t v;
    v.stall = st;  v.flush = fl;  v.wd = wd;  v.wreg = wreg;  v.wdata = wdata;
    v.hi = hi;  v.lo = lo;  v.whilo = whilo;  v.hilo = hilo;  v.cnt = cnt;
    v.e_wd = e_wd;  v.e_wreg = e_wreg;  v.e_wdata = e_wdata;  v.e_hi = e_hi;
    v.e_lo = e_lo;  v.e_whilo = e_whilo;  v.e_hilo = e_hilo;  v.e_cnt = e_cnt;
    v.e_bub = e_bub;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, req);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".mem_wd"},    {59'd0, mem_wd},    64'd0);
    chk({tag, ".mem_wreg"},  {63'd0, mem_wreg},  64'd0);
    chk({tag, ".mem_wdata"}, {32'd0, mem_wdata}, 64'd0);
    chk({tag, ".mem_hi"},    {32'd0, mem_hi},    64'd0);
    chk({tag, ".mem_lo"},    {32'd0, mem_lo},    64'd0);
    chk({tag, ".mem_whilo"}, {63'd0, mem_whilo}, 64'd0);
    chk({tag, ".hilo_o"},    hilo_o,             64'd0);
    chk({tag, ".cnt_o"},     {62'd0, cnt_o},     64'd0);
`ifdef EXMEM_PERF_CNT_EN
    chk({tag, ".bubble_cnt"}, {32'd0, bubble_cnt}, 64'd0);
`endif
  endtask

  task automatic drive(input vec_t v);
    stall = v.stall;  flush = v.flush;  ex_wd = v.wd;  ex_wreg = v.wreg;
    ex_wdata = v.wdata;  ex_hi = v.hi;  ex_lo = v.lo;  ex_whilo = v.whilo;
    hilo_i = v.hilo;  cnt_i = v.cnt;
  endtask

  initial begin
    exp_t e;
    vec_t v;
    string tag;
    checks = 0;
    failures = 0;

    // Vectors run back to back after reset; hold rows repeat the prior state.
    //            stall      fl wd     wr  wdata          hi            lo            whl hilo_i                  cnt   | e_wd  e_wr e_wdata        e_hi          e_lo          e_whl e_hilo                  e_cnt e_bub
    vecs[0]  = mkv(6'b000000,1'b0,5'd3, 1'b1,32'h1234_5678,32'h0000_000A,32'h0000_000B,1'b1,64'h0000_0000_0000_0055,2'd2, 5'd3, 1'b1,32'h1234_5678,32'h0000_000A,32'h0000_000B,1'b1,64'd0,                   2'd0, 32'd0);
    vecs[1]  = mkv(6'b001111,1'b0,5'd9, 1'b1,32'h1111_1111,32'h2222_2222,32'h3333_3333,1'b1,64'h0000_0001_0000_0002,2'd1, 5'd0, 1'b0,32'd0,         32'd0,        32'd0,        1'b0,64'h0000_0001_0000_0002,2'd1, 32'd1);
    vecs[2]  = mkv(6'b000000,1'b0,5'd4, 1'b1,32'hCAFE_0001,32'h0000_0010,32'h0000_0020,1'b1,64'h0000_0000_0000_0777,2'd1, 5'd4, 1'b1,32'hCAFE_0001,32'h0000_0010,32'h0000_0020,1'b1,64'd0,                   2'd0, 32'd1);
    vecs[3]  = mkv(6'b011111,1'b0,5'd17,1'b0,32'h5555_AAAA,32'h0F0F_0F0F,32'hF0F0_F0F0,1'b0,64'hFFFF_0000_FFFF_0000,2'd3, 5'd4, 1'b1,32'hCAFE_0001,32'h0000_0010,32'h0000_0020,1'b1,64'd0,                   2'd0, 32'd1);
    vecs[4]  = mkv(6'b011111,1'b0,5'd30,1'b1,32'hAAAA_5555,32'hF0F0_F0F0,32'h0F0F_0F0F,1'b1,64'h0000_FFFF_0000_FFFF,2'd2, 5'd4, 1'b1,32'hCAFE_0001,32'h0000_0010,32'h0000_0020,1'b1,64'd0,                   2'd0, 32'd1);
    vecs[5]  = mkv(6'b011111,1'b0,5'd1, 1'b0,32'h0000_0001,32'h0000_0002,32'h0000_0003,1'b0,64'h1234_5678_9ABC_DEF0,2'd1, 5'd4, 1'b1,32'hCAFE_0001,32'h0000_0010,32'h0000_0020,1'b1,64'd0,                   2'd0, 32'd1);
    vecs[6]  = mkv(6'b001111,1'b0,5'd8, 1'b1,32'h8888_8888,32'h9999_9999,32'h7777_7777,1'b1,64'hDEAD_0000_BEEF_0001,2'd2, 5'd0, 1'b0,32'd0,         32'd0,        32'd0,        1'b0,64'hDEAD_0000_BEEF_0001,2'd2, 32'd2);
    vecs[7]  = mkv(6'b011111,1'b0,5'd12,1'b1,32'h0BAD_F00D,32'h1,         32'h2,         1'b1,64'h0000_0000_0000_0003,2'd3, 5'd0, 1'b0,32'd0,         32'd0,        32'd0,        1'b0,64'hDEAD_0000_BEEF_0001,2'd2, 32'd2);
    vecs[8]  = mkv(6'b011111,1'b0,5'd13,1'b0,32'hF00D_0BAD,32'h3,         32'h4,         1'b0,64'h0000_0000_0000_0004,2'd1, 5'd0, 1'b0,32'd0,         32'd0,        32'd0,        1'b0,64'hDEAD_0000_BEEF_0001,2'd2, 32'd2);
    vecs[9]  = mkv(6'b010000,1'b0,5'd14,1'b1,32'h1357_9BDF,32'h5,         32'h6,         1'b1,64'h0000_0000_0000_0005,2'd3, 5'd0, 1'b0,32'd0,         32'd0,        32'd0,        1'b0,64'hDEAD_0000_BEEF_0001,2'd2, 32'd2);
    vecs[10] = mkv(6'b001111,1'b1,5'd15,1'b1,32'h2468_ACE0,32'h7,         32'h8,         1'b1,64'h0000_0000_0000_0006,2'd1, 5'd0, 1'b0,32'd0,         32'd0,        32'd0,        1'b0,64'd0,                   2'd0, 32'd2);
    vecs[11] = mkv(6'b000000,1'b0,5'd31,1'b0,32'hFFFF_FFFF,32'hFFFF_FFFF,32'h0000_0000,1'b0,64'hFFFF_FFFF_FFFF_FFFF,2'd3, 5'd31,1'b0,32'hFFFF_FFFF,32'hFFFF_FFFF,32'h0000_0000,1'b0,64'd0,                   2'd0, 32'd2);
    vecs[12] = mkv(6'b000000,1'b1,5'd21,1'b1,32'h0000_00FF,32'h9,         32'hA,         1'b1,64'h0000_0000_0000_0007,2'd2, 5'd0, 1'b0,32'd0,         32'd0,        32'd0,        1'b0,64'd0,                   2'd0, 32'd2);
    vecs[13] = mkv(6'b101111,1'b0,5'd22,1'b1,32'h0000_0F00,32'hB,         32'hC,         1'b1,64'h0000_0000_0000_0001,2'd3, 5'd0, 1'b0,32'd0,         32'd0,        32'd0,        1'b0,64'h0000_0000_0000_0001,2'd3, 32'd3);
    vecs[14] = mkv(6'b011111,1'b1,5'd23,1'b1,32'h0000_F000,32'hD,         32'hE,         1'b1,64'h0000_0000_0000_0009,2'd1, 5'd0, 1'b0,32'd0,         32'd0,        32'd0,        1'b0,64'd0,                   2'd0, 32'd3);

    // Reset the DUT with idle inputs.
    rst = 1'b1;  stall = 6'd0;  flush = 1'b0;  ex_wd = 5'd0;  ex_wreg = 1'b0;
    ex_wdata = 32'd0;  ex_hi = 32'd0;  ex_lo = 32'd0;  ex_whilo = 1'b0;
    hilo_i = 64'd0;  cnt_i = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Table-driven run through the scoreboard.
    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      drive(v);
      e.wd = v.e_wd;  e.wreg = v.e_wreg;  e.wdata = v.e_wdata;  e.hi = v.e_hi;
      e.lo = v.e_lo;  e.whilo = v.e_whilo;  e.hilo = v.e_hilo;  e.cnt = v.e_cnt;
      e.bub = v.e_bub;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      tag = $sformatf("v%0d", i);
      chk({tag, ".mem_wd"},    {59'd0, mem_wd},    {59'd0, e.wd});
      chk({tag, ".mem_wreg"},  {63'd0, mem_wreg},  {63'd0, e.wreg});
      chk({tag, ".mem_wdata"}, {32'd0, mem_wdata}, {32'd0, e.wdata});
      chk({tag, ".mem_hi"},    {32'd0, mem_hi},    {32'd0, e.hi});
      chk({tag, ".mem_lo"},    {32'd0, mem_lo},    {32'd0, e.lo});
      chk({tag, ".mem_whilo"}, {63'd0, mem_whilo}, {63'd0, e.whilo});
      chk({tag, ".hilo_o"},    hilo_o,             e.hilo);
      chk({tag, ".cnt_o"},     {62'd0, cnt_o},     {62'd0, e.cnt});
`ifdef EXMEM_PERF_CNT_EN
      chk({tag, ".bubble_cnt"}, {32'd0, bubble_cnt}, {32'd0, e.bub});
`endif
      @(negedge clk);
    end

    // Async reset mid-cycle with a live EX bundle captured.
    stall = 6'd0;  flush = 1'b0;  ex_wd = 5'd7;  ex_wreg = 1'b1;
    ex_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    chk("rstseq.pre_wd", {59'd0, mem_wd}, 64'd7);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("rst_mid");
    @(negedge clk);
    rst = 1'b0;

    // Async reset in the middle of a madd sequence abandons the partial product.
    stall = 6'b001111;  hilo_i = 64'h0000_0001_0000_0002;  cnt_i = 2'b01;
    @(posedge clk);
    #1;
    chk("madd.pre_hilo", hilo_o, 64'h0000_0001_0000_0002);
    chk("madd.pre_cnt", {62'd0, cnt_o}, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("rst_madd");
    @(negedge clk);
    rst = 1'b0;
    stall = 6'd0;

`ifdef EXMEM_PERF_CNT_EN
    // Counter wrap: preload the maximum value then apply one bubble.
    force dut.r_bubble_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_bubble_cnt;
    chk("wrap.preload", {32'd0, bubble_cnt}, 64'h0000_0000_FFFF_FFFF);
    stall = 6'b001111;
    @(posedge clk);
    #1;
    chk("wrap.bubble_cnt", {32'd0, bubble_cnt}, 64'd0);
    @(negedge clk);
    stall = 6'd0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
